mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Two-port arbiter and sequencer that shares the single shift-add multiplier between two requesters: the SPI-side front end (port 0) and a local host (port 1).
- Selects one pending request round-robin and registers its operands onto the multiplier inputs.
- Issues the one-cycle `start` pulse, waits for `done`, captures the product and returns it to the owning port with a one-cycle valid strobe.
- Sits between the requester FSMs and the multiplier datapath, which then has exactly one driver.

## Interface
Parameters:
- `WIDTH`, 8, operand width; product is 2*WIDTH.
- `TIMEOUT`, 255, maximum cycles spent in WAIT (used only with `MULT_ARB_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  level request per port; held until that port's `res_valid` is seen.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands; must be stable while the matching `req` is high.
- `mult_a`, `mult_b`  out  WIDTH  registered operands driven to the multiplier.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_done`  in  1  multiplier completion flag.
- `mult_res`  in  2*WIDTH  multiplier product; valid when `mult_done`=1.
- `res`  out  2*WIDTH  registered product, held until the next capture.
- `res_valid0`, `res_valid1`  out  1  one-cycle result strobe per port.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle timeout strobe; tied 0 without `MULT_ARB_TIMEOUT_EN`.

## Operation
States: IDLE, START, WAIT, RESP.

- **IDLE**
  - If no `req` is high, stay in IDLE.
  - If exactly one `req` is high, grant that port.
  - If both are high, grant the port named by the priority pointer `ptr`.
  - On grant: `owner` <= granted port; `mult_a`/`mult_b` <= that port's operands; `mult_start` <= 1; next state START.
- **START**
  - `mult_start` <= 0; next state WAIT.
  - `mult_done` is ignored in this state.
- **WAIT**
  - On `mult_done`=1: `res` <= `mult_res`; `res_valid[owner]` <= 1; next state RESP.
- **RESP**
  - `res_valid*` <= 0; `ptr` <= ~`owner`; next state IDLE.
- `mult_done` is ignored in IDLE, START and RESP.
- A `req` still high when the FSM re-enters IDLE is treated as a new request. Requesters drop `req` in the cycle in which they see their `res_valid`.
- Round-robin rule: after port N is served, port ~N wins the next tie. A lone request is always granted regardless of `ptr`.
- Reset (asynchronous, any state): state IDLE; `ptr`=0; `owner`=0; `mult_a`=`mult_b`=0; `res`=0; `mult_start`=0; `res_valid0`=`res_valid1`=0; `err`=0; `busy`=0.
  - An in-flight multiplication is abandoned and no result is delivered.
  - The multiplier must be reset alongside this block.

## Timing
Edge E0 samples `req` high in IDLE.
- After E0: `mult_a`/`mult_b` are valid and `mult_start`=1 for exactly one cycle.
- After E1: state is WAIT.
- Edge Ek is the first edge in WAIT that samples `mult_done`=1. After Ek: `res` and `res_valid[owner]` are valid for exactly one cycle.
- After Ek+1: state is IDLE. The earliest next grant is at edge Ek+2.
- Overhead: 3 cycles plus multiplier latency from request sample to result strobe.
- `busy` goes high after E0 and low after Ek+1.
- `mult_a`/`mult_b` hold their value from grant until the next grant, covering the multiplier's load phase.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A WIDTH-independent 16-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches `TIMEOUT` before `mult_done`: `res` <= 0; `res_valid[owner]` <= 1; `err` <= 1, all for one cycle; next state RESP.
  - If `mult_done` and the timeout occur on the same edge, `mult_done` wins and `err` stays 0.
- `MULT_ARB_TIMEOUT_EN` undefined:
  - No counter is built; WAIT holds indefinitely.
  - `err` is constant 0.

## Test plan
- **Single request:** after reset, `req0`=1, `a0`=8'd12, `b0`=8'd11; multiplier model asserts `done` 9 cycles after start. Required: `mult_start` is high for 1 cycle after the grant edge; `res`=16'd132 with `res_valid0` for 1 cycle; `res_valid1` stays 0.
- **Simultaneous requests:** `req0`=`req1`=1 from reset, with (3,5) and (7,9). Required: port 0 is served first (`res`=15), then port 1 (`res`=63); grants are back-to-back, with the port-1 grant at the edge after RESP.
- **Fairness:** hold `req1` high continuously; re-raise `req0` after each of its results. Required: grants alternate 0,1,0,1 and neither port is served twice in a row while the other is pending.
- **Spurious done:** pulse `mult_done` in IDLE and in START. Required: no `res_valid`, `res` unchanged, FSM follows the normal sequence.
- **Reset mid-operation:** assert `reset` in WAIT. Required: all outputs read 0 immediately, no `res_valid` is emitted, and the next request after `reset` falls is granted to port 0.
- **Timeout** (`MULT_ARB_TIMEOUT_EN`, `TIMEOUT`=20, `done` never asserted): required `res`=0, `res_valid[owner]`=1 and `err`=1, all on the same cycle, 20 cycles after entering WAIT; the FSM then returns to IDLE.

Source files
------------

// File: rtl/mult_share_arb.sv
// Purpose : round-robin arbiter/sequencer sharing one shift-add multiplier between port 0 (SPI front end) and port 1 (host).
// Latency : grant edge -> start pulse next cycle; result strobe 1 cycle after the edge that samples mult_done (3 cycles + multiplier latency).
// Backpress: level req held until the port's res_valid strobe; a second request waits in IDLE until the FSM has returned from RESP.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req0/req1, a0/b0/a1/b1  per-port level request and operands (stable while req is high)
//   mult_a/mult_b/mult_start registered operands and one-cycle start pulse to the multiplier
//   mult_done/mult_res      multiplier completion flag and product
//   res, res_valid0/1       registered product and one-cycle per-port result strobe
//   busy, err               FSM not in IDLE; one-cycle timeout strobe
//
// Optional build macro: MULT_ARB_TIMEOUT_EN adds a 16-bit WAIT watchdog that answers with res=0 and err=1
// after TIMEOUT cycles. Without it WAIT holds indefinitely and err is constant 0.
module mult_share_arb #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  output logic               mult_start,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_res,
  output logic [2*WIDTH-1:0] res,
  output logic               res_valid0,
  output logic               res_valid1,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [WIDTH-1:0]   mult_b_q, mult_b_d;
  logic               mult_start_q, mult_start_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               res_valid0_q, res_valid0_d;
  logic               res_valid1_q, res_valid1_d;
  logic               err_q, err_d;

  logic any_req;
  logic grant;
  logic timeout_hit;

`ifdef MULT_ARB_TIMEOUT_EN
  // Counter value seen on the WAIT edge that is the TIMEOUT-th one.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_START) begin
      wait_cnt_d = '0;                    // cleared on the edge that enters WAIT
    end else if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_hit = (wait_cnt_q == TIMEOUT_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  assign any_req = req0 | req1;
  // Tie goes to ptr; a lone request wins regardless of ptr.
  assign grant   = (req0 & req1) ? ptr_q : req1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    mult_start_d = 1'b0;
    res_d        = res_q;
    res_valid0_d = 1'b0;
    res_valid1_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d      = grant;
          mult_a_d     = grant ? a1 : a0;
          mult_b_d     = grant ? b1 : b0;
          mult_start_d = 1'b1;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        // mult_done is ignored here: the multiplier has not loaded yet.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over a timeout on the same edge.
        if (mult_done) begin
          res_d        = mult_res;
          res_valid0_d = ~owner_q;
          res_valid1_d = owner_q;
          state_d      = ST_RESP;
        end else if (timeout_hit) begin
          res_d        = '0;
          res_valid0_d = ~owner_q;
          res_valid1_d = owner_q;
          err_d        = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d   = ~owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_start_q <= 1'b0;
      res_q        <= '0;
      res_valid0_q <= 1'b0;
      res_valid1_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      mult_start_q <= mult_start_d;
      res_q        <= res_d;
      res_valid0_q <= res_valid0_d;
      res_valid1_q <= res_valid1_d;
      err_q        <= err_d;
    end
  end

  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign mult_start = mult_start_q;
  assign res        = res_q;
  assign res_valid0 = res_valid0_q;
  assign res_valid1 = res_valid1_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_share_arb.sv
// Purpose : self-checking bench for mult_share_arb with a behavioural multiplier and a result scoreboard.
// Latency : multiplier model raises done m_lat cycles after it sees the start pulse.
// Backpress: requesters drop req on their res_valid strobe (port 1 may be held high for the fairness scenario).
module tb_mult_share_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [7:0]  mult_a, mult_b;
  logic        mult_start;
  logic        mult_done = 1'b0;
  logic [15:0] mult_res = 16'hBEEF;
  logic [15:0] res;
  logic        res_valid0, res_valid1, busy, err;

  always #5 clk = ~clk;

  mult_share_arb #(.WIDTH(8), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_done(mult_done), .mult_res(mult_res),
    .res(res), .res_valid0(res_valid0), .res_valid1(res_valid1),
    .busy(busy), .err(err)
  );

  typedef struct { int cyc; logic [1:0] rv; logic [15:0] res; logic err; } obs_t;
  typedef struct { logic [1:0] rv; logic [15:0] res; logic err; } exp_t;
  typedef struct { int cyc; logic [7:0] a; } grant_t;

  obs_t   obs_q[$];
  exp_t   exp_q[$];
  grant_t grant_q[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          m_cnt = 0;
  int          m_lat = 9;
  logic [15:0] m_prod = '0;
  bit          m_hang = 1'b0;
  bit          hold1 = 1'b0;

  // One clock step: sample at negedge, log grants/results, act as requesters and as the multiplier.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mult_start) grant_q.push_back('{cyc, mult_a});
    if (res_valid0 || res_valid1) begin
      obs_q.push_back('{cyc, {res_valid1, res_valid0}, res, err});
      if (res_valid0) req0 = 1'b0;
      if (res_valid1 && !hold1) req1 = 1'b0;
    end
    mult_done = 1'b0;
    mult_res  = 16'hBEEF;
    if (reset) begin
      m_cnt = 0;
    end else if (mult_start) begin
      m_cnt  = m_lat;
      m_prod = 16'(mult_a) * 16'(mult_b);
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0 && !m_hang) begin
        mult_done = 1'b1;
        mult_res  = m_prod;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
    grant_q.delete();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({mult_a, mult_b, mult_start, res, res_valid0, res_valid1, err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%0d b=%0d start=%b res=%0d rv=%b%b err=%b busy=%b, want all 0",
               mult_a, mult_b, mult_start, res, res_valid1, res_valid0, err, busy);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || grant_q.size() != 0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b grants=%0d, want busy=0 grants=0", busy, grant_q.size());
    end
  endtask

  task automatic test_single();
    int c_req;
    obs_t o;
    exp_t e;
    a0 = 8'd12; b0 = 8'd11; req0 = 1'b1;
    exp_q.push_back('{2'b01, 16'd132, 1'b0});
    c_req = cyc;
    repeat (30) tick();
    total++;
    if (grant_q.size() != 1 || grant_q[0].cyc != c_req + 1) begin
      bad++;
      $display("FAIL single_start: start pulses=%0d first at %0d, want 1 pulse at %0d",
               grant_q.size(), (grant_q.size() != 0) ? grant_q[0].cyc : -1, c_req + 1);
    end
    total++;
    if (obs_q.size() != 1 || grant_q.size() == 0 || obs_q[0].cyc != grant_q[0].cyc + m_lat + 1) begin
      bad++;
      $display("FAIL single_latency: strobes=%0d first at %0d, want 1 strobe at start+%0d",
               obs_q.size(), (obs_q.size() != 0) ? obs_q[0].cyc : -1, m_lat + 1);
    end
    total++;
    if ({mult_a, mult_b, res, busy, res_valid0, res_valid1} !== {8'd12, 8'd11, 16'd132, 3'b000}) begin
      bad++;
      $display("FAIL single_hold: got a=%0d b=%0d res=%0d busy=%b rv=%b%b, want 12 11 132 0 00",
               mult_a, mult_b, res, busy, res_valid1, res_valid0);
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL single_sb_extra: got rv=%b res=%0d, want no result", o.rv, o.res);
      end else begin
        e = exp_q.pop_front();
        if ({o.rv, o.res, o.err} !== {e.rv, e.res, e.err}) begin
          bad++;
          $display("FAIL single_sb: got rv=%b res=%0d err=%b, want rv=%b res=%0d err=%b",
                   o.rv, o.res, o.err, e.rv, e.res, e.err);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_sb_missing: got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    int s0;
    obs_t o;
    exp_t e;
    do_reset();
    a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{2'b01, 16'd15, 1'b0});
    exp_q.push_back('{2'b10, 16'd63, 1'b0});
    for (int i = 0; i < 100 && obs_q.size() < 2; i++) tick();
    repeat (3) tick();
    total++;
    if (grant_q.size() != 2 || grant_q[0].a != 8'd3 || grant_q[1].a != 8'd7) begin
      bad++;
      $display("FAIL simul_order: grants=%0d, want 2 grants with mult_a 3 then 7", grant_q.size());
    end
    s0 = (obs_q.size() != 0) ? obs_q[0].cyc : -100;
    total++;
    if (grant_q.size() < 2 || grant_q[1].cyc != s0 + 2) begin
      bad++;
      $display("FAIL simul_b2b: second start at %0d, want %0d", (grant_q.size() > 1) ? grant_q[1].cyc : -1, s0 + 2);
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL simul_sb_extra: got rv=%b res=%0d, want no result", o.rv, o.res);
      end else begin
        e = exp_q.pop_front();
        if ({o.rv, o.res, o.err} !== {e.rv, e.res, e.err}) begin
          bad++;
          $display("FAIL simul_sb: got rv=%b res=%0d err=%b, want rv=%b res=%0d err=%b",
                   o.rv, o.res, o.err, e.rv, e.res, e.err);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL simul_sb_missing: got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_fairness();
    bit pend;
    obs_t o;
    exp_t e;
    do_reset();
    pend = 1'b0;
    hold1 = 1'b1;
    a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back((k % 2 == 0) ? '{2'b01, 16'd15, 1'b0} : '{2'b10, 16'd63, 1'b0});
    for (int i = 0; i < 200 && obs_q.size() < 4; i++) begin
      tick();
      if (pend) begin
        req0 = 1'b1;
        pend = 1'b0;
      end else if (!req0) begin
        pend = 1'b1;
      end
    end
    hold1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();
    total++;
    if (grant_q.size() != 4) begin
      bad++;
      $display("FAIL fair_count: got %0d grants, want 4", grant_q.size());
    end
    for (int k = 0; k < 4 && k < grant_q.size(); k++) begin
      total++;
      if (grant_q[k].a !== ((k % 2 == 0) ? 8'd3 : 8'd7)) begin
        bad++;
        $display("FAIL fair_alt: grant %0d has mult_a=%0d, want %0d", k, grant_q[k].a, (k % 2 == 0) ? 3 : 7);
      end
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fair_sb_extra: got rv=%b res=%0d, want no result", o.rv, o.res);
      end else begin
        e = exp_q.pop_front();
        if ({o.rv, o.res, o.err} !== {e.rv, e.res, e.err}) begin
          bad++;
          $display("FAIL fair_sb: got rv=%b res=%0d err=%b, want rv=%b res=%0d err=%b",
                   o.rv, o.res, o.err, e.rv, e.res, e.err);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL fair_sb_missing: got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_spurious();
    logic [15:0] res_before;
    int c_req;
    obs_t o;
    exp_t e;
    obs_q.delete();
    grant_q.delete();
    res_before = res;
    mult_done = 1'b1;                     // stray done while idle
    mult_res  = 16'h1234;
    tick();
    tick();
    total++;
    if (obs_q.size() != 0 || res !== res_before || busy !== 1'b0 || grant_q.size() != 0) begin
      bad++;
      $display("FAIL spur_idle: strobes=%0d res=%0d busy=%b grants=%0d, want 0 %0d 0 0",
               obs_q.size(), res, busy, grant_q.size(), res_before);
    end
    a0 = 8'd6; b0 = 8'd7; req0 = 1'b1;
    exp_q.push_back('{2'b01, 16'd42, 1'b0});
    c_req = cyc;
    tick();                               // FSM now in START
    mult_done = 1'b1;                     // stray done while in START
    mult_res  = 16'h5678;
    tick();
    total++;
    if (obs_q.size() != 0 || res !== res_before || busy !== 1'b1) begin
      bad++;
      $display("FAIL spur_start: strobes=%0d res=%0d busy=%b, want 0 %0d 1", obs_q.size(), res, busy, res_before);
    end
    repeat (20) tick();
    total++;
    if (grant_q.size() != 1 || grant_q[0].cyc != c_req + 1 || obs_q.size() != 1 ||
        obs_q[0].cyc != c_req + 2 + m_lat) begin
      bad++;
      $display("FAIL spur_seq: grants=%0d strobes=%0d strobe at %0d, want 1 1 %0d",
               grant_q.size(), obs_q.size(), (obs_q.size() != 0) ? obs_q[0].cyc : -1, c_req + 2 + m_lat);
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spur_sb_extra: got rv=%b res=%0d, want no result", o.rv, o.res);
      end else begin
        e = exp_q.pop_front();
        if ({o.rv, o.res, o.err} !== {e.rv, e.res, e.err}) begin
          bad++;
          $display("FAIL spur_sb: got rv=%b res=%0d err=%b, want rv=%b res=%0d err=%b",
                   o.rv, o.res, o.err, e.rv, e.res, e.err);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL spur_sb_missing: got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    // Port 0 was served last, so ptr now favours port 1; reset must restore port 0 priority.
    obs_q.delete();
    grant_q.delete();
    a1 = 8'd10; b1 = 8'd10; req1 = 1'b1;
    for (int i = 0; i < 10 && grant_q.size() == 0; i++) tick();
    repeat (3) tick();                    // now in WAIT
    reset = 1'b1;
    #1;
    total++;
    if ({mult_a, mult_b, mult_start, res, res_valid0, res_valid1, err, busy} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got a=%0d b=%0d start=%b res=%0d rv=%b%b err=%b busy=%b, want all 0",
               mult_a, mult_b, mult_start, res, res_valid1, res_valid0, err, busy);
    end
    req1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (15) tick();
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL midreset_nores: got %0d strobes after reset, want 0", obs_q.size());
    end
    grant_q.delete();
    a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{2'b01, 16'd15, 1'b0});
    exp_q.push_back('{2'b10, 16'd63, 1'b0});
    for (int i = 0; i < 100 && obs_q.size() < 2; i++) tick();
    repeat (3) tick();
    total++;
    if (grant_q.size() == 0 || grant_q[0].a !== 8'd3) begin
      bad++;
      $display("FAIL midreset_ptr: first grant mult_a=%0d, want 3 (port 0)",
               (grant_q.size() != 0) ? grant_q[0].a : 8'd0);
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL midreset_sb_extra: got rv=%b res=%0d, want no result", o.rv, o.res);
      end else begin
        e = exp_q.pop_front();
        if ({o.rv, o.res, o.err} !== {e.rv, e.res, e.err}) begin
          bad++;
          $display("FAIL midreset_sb: got rv=%b res=%0d err=%b, want rv=%b res=%0d err=%b",
                   o.rv, o.res, o.err, e.rv, e.res, e.err);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL midreset_sb_missing: got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

`ifdef MULT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    do_reset();
    m_hang = 1'b1;
    a0 = 8'd2; b0 = 8'd3; req0 = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < 1; i++) tick();
    tick();
    m_hang = 1'b0;
    total++;
    if (obs_q.size() != 1 || grant_q.size() != 1) begin
      bad++;
      $display("FAIL timeout_strobe: got %0d strobes %0d grants, want 1 1", obs_q.size(), grant_q.size());
    end else begin
      o = obs_q.pop_front();
      total++;
      if ({o.rv, o.res, o.err} !== {2'b01, 16'd0, 1'b1} || o.cyc != grant_q[0].cyc + 21) begin
        bad++;
        $display("FAIL timeout_resp: got rv=%b res=%0d err=%b at %0d, want rv=01 res=0 err=1 at %0d",
                 o.rv, o.res, o.err, o.cyc, grant_q[0].cyc + 21);
      end
    end
    total++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_after: got err=%b busy=%b, want 0 0", err, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_spurious();
    test_reset_mid();
`ifdef MULT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1);
  end

endmodule
